// File: rtl/updown_arb_ctrl.sv
// Round-robin arbiter that serialises single-step up/down requests onto one shared counter.
// An optional saturation guard rejects any step that would wrap the counter.
module updown_arb_ctrl #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int SAT   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [NREQ-1:0]  req_valid,
   input  logic [NREQ-1:0]  req_dir,
   output logic [NREQ-1:0]  req_ack,
   output logic [NREQ-1:0]  req_err,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             cnt_up,
   output logic             cnt_down,
   output logic             busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [IW-1:0] r_rr;
   logic [IW-1:0] r_gnt;
   logic          r_dir;
   logic [IW-1:0] w_sel;
   logic          w_any;
   logic          w_grant;
   logic          w_blocked;

   // First valid requester at or above the rr pointer, wrapping modulo NREQ.
   always_comb begin : pick
      int v_idx;
      w_sel = r_rr;
      w_any = 1'b0;
      v_idx = 0;
      for (int i = 0; i < NREQ; i++) begin
         v_idx = (int'(r_rr) + i) % NREQ;
         if (!w_any && req_valid[v_idx]) begin
            w_any = 1'b1;
            w_sel = IW'(v_idx);
         end
      end
   end

   assign w_grant   = (r_state == S_IDLE) && enable && w_any;
   assign w_blocked = (SAT != 0) &&
                      ((r_dir && (cnt_value == '1)) || (!r_dir && (cnt_value == '0)));

   // NOTE: every output gets a default before the case so no path leaves one unassigned, which would infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      req_ack     = '0;
      req_err     = '0;
      cnt_up      = 1'b0;
      cnt_down    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            w_state_nxt    = S_IDLE;
            busy           = 1'b1;
            req_ack[r_gnt] = 1'b1;
            if (w_blocked) begin
               req_err[r_gnt] = 1'b1;
            end else begin
               cnt_up   = r_dir;
               cnt_down = ~r_dir;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode from r_state only, so the async reset drops them immediately mid-ISSUE.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_rr    <= '0;
         r_gnt   <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_gnt <= w_sel;
            r_dir <= req_dir[w_sel];
         end
         if (r_state == S_ISSUE) begin
            r_rr <= (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_updown_arb_ctrl.sv
// Directed bench for updown_arb_ctrl: a saturating instance and a wrapping instance,
// each driving a behavioural 4-bit counter; acks are checked against a scoreboard queue.
module tb_updown_arb_ctrl;

   typedef struct {
      int idx;
      bit err;
      bit up;
      bit down;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic [3:0] req_valid = '0;
   logic [3:0] req_dir = '0;
   logic [3:0] req_ack, req_err;
   logic       cnt_up, cnt_down, busy;
   logic [3:0] cnt;

   logic [3:0] b_valid = '0;
   logic [3:0] b_dir = '0;
   logic [3:0] b_ack, b_err;
   logic       b_up, b_down, b_busy;
   logic [3:0] b_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   updown_arb_ctrl #(.NREQ(4), .WIDTH(4), .SAT(1)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req_valid(req_valid), .req_dir(req_dir),
      .req_ack(req_ack), .req_err(req_err),
      .cnt_value(cnt), .cnt_up(cnt_up), .cnt_down(cnt_down), .busy(busy)
   );

   updown_arb_ctrl #(.NREQ(4), .WIDTH(4), .SAT(0)) dut_wrap (
      .clk(clk), .reset(reset), .enable(1'b1),
      .req_valid(b_valid), .req_dir(b_dir),
      .req_ack(b_ack), .req_err(b_err),
      .cnt_value(b_cnt), .cnt_up(b_up), .cnt_down(b_down), .busy(b_busy)
   );

   // Behavioural counters: async reset, up has priority over down.
   always @(posedge clk or posedge reset) begin
      if (reset)         cnt <= '0;
      else if (cnt_up)   cnt <= cnt + 4'd1;
      else if (cnt_down) cnt <= cnt - 4'd1;
   end

   always @(posedge clk or posedge reset) begin
      if (reset)       b_cnt <= '0;
      else if (b_up)   b_cnt <= b_cnt + 4'd1;
      else if (b_down) b_cnt <= b_cnt - 4'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor plus per-cycle invariants, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         check("inv_up_and_down", {31'b0, cnt_up & cnt_down}, 32'd0);
         check("inv_ack_onehot", {31'b0, $onehot0(req_ack)}, 32'd1);
         check("inv_err_without_ack", {28'b0, req_err & ~req_ack}, 32'd0);
         check("inv_wrap_up_and_down", {31'b0, b_up & b_down}, 32'd0);
         if (|req_ack) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", {28'b0, req_ack}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("ack_index", {28'b0, req_ack}, 32'd1 << e.idx);
               check("err_bits", {28'b0, req_err}, e.err ? (32'd1 << e.idx) : 32'd0);
               check("cnt_up", {31'b0, cnt_up}, {31'b0, e.up});
               check("cnt_down", {31'b0, cnt_down}, {31'b0, e.down});
               check("busy_with_ack", {31'b0, busy}, 32'd1);
            end
         end
      end
   end

   task automatic push(input int idx, input bit err, input bit up, input bit down);
      exp_t e;
      e.idx = idx; e.err = err; e.up = up; e.down = down;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(|req_ack) && n < max);
      if (!(|req_ack)) check("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic single_op(input logic [3:0] v, input logic [3:0] d, input int idx, input bit err);
      int n;
      push(idx, err, !err && d[idx], !err && !d[idx]);
      @(posedge clk) #1;
      req_valid = v;
      req_dir   = d;
      wait_ack(4, n);
      @(posedge clk) #1;
      req_valid = '0;
   endtask

   task automatic do_reset();
      @(posedge clk) #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_ack", {28'b0, req_ack}, 32'd0);
      check("rst_err", {28'b0, req_err}, 32'd0);
      check("rst_outs", {29'b0, cnt_up, cnt_down, busy}, 32'd0);
      check("rst_cnt", {28'b0, cnt}, 32'd0);
      @(posedge clk) #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [3:0] acc;

      // Reset state and one up op from requester 0.
      do_reset();
      single_op(4'b0001, 4'b0001, 0, 1'b0);
      check("first_op_cnt", {28'b0, cnt}, 32'd1);

      // All four requesters up continuously from 0: 15 steps then a saturating reject.
      do_reset();
      for (int i = 0; i < 16; i++) push(i % 4, i == 15, i != 15, 1'b0);
      @(posedge clk) #1;
      req_valid = 4'b1111;
      req_dir   = 4'b1111;
      for (int i = 0; i < 16; i++) begin
         wait_ack(4, n);
         check("rr_ack_spacing", n, 32'd2);
      end
      @(posedge clk) #1;
      req_valid = '0;
      check("saturated_cnt", {28'b0, cnt}, 32'd15);

      // Down at zero: rejected when saturating, wraps when not.
      do_reset();
      single_op(4'b0100, 4'b0000, 2, 1'b1);
      check("down_at_zero_cnt", {28'b0, cnt}, 32'd0);

      @(posedge clk) #1;
      b_valid = 4'b0100;
      b_dir   = 4'b0000;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(|b_ack) && n < 4);
      check("wrap_ack", {28'b0, b_ack}, 32'h4);
      check("wrap_err", {28'b0, b_err}, 32'h0);
      check("wrap_updown", {30'b0, b_up, b_down}, 32'h1);
      @(posedge clk) #1;
      b_valid = '0;
      check("wrap_cnt", {28'b0, b_cnt}, 32'd15);

      // Opposing requests from cnt=5 with rr pointer 0 (last grant was requester 3).
      do_reset();
      for (int i = 0; i < 5; i++) single_op(4'b1000, 4'b1000, 3, 1'b0);
      check("preload_cnt", {28'b0, cnt}, 32'd5);
      push(0, 1'b0, 1'b1, 1'b0);
      push(1, 1'b0, 1'b0, 1'b1);
      @(posedge clk) #1;
      req_valid = 4'b0011;
      req_dir   = 4'b0001;
      wait_ack(4, n);
      @(posedge clk) #1;
      req_valid = 4'b0010;
      check("conflict_first_cnt", {28'b0, cnt}, 32'd6);
      wait_ack(4, n);
      @(posedge clk) #1;
      req_valid = '0;
      check("conflict_second_cnt", {28'b0, cnt}, 32'd5);

      // enable low holds the request off; raising it grants within two cycles.
      @(posedge clk) #1;
      enable    = 1'b0;
      req_valid = 4'b0010;
      req_dir   = 4'b0010;
      acc = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         acc |= req_ack;
      end
      check("disabled_no_ack", {28'b0, acc}, 32'd0);
      push(1, 1'b0, 1'b1, 1'b0);
      @(posedge clk) #1;
      enable = 1'b1;
      wait_ack(2, n);
      @(posedge clk) #1;
      req_valid = '0;
      check("enable_op_cnt", {28'b0, cnt}, 32'd6);

      // Reset inside ISSUE: rr pointer is 2, so requester 2 is granted then aborted.
      @(posedge clk) #1;
      req_valid = 4'b0101;
      req_dir   = 4'b0101;
      @(posedge clk) #1;
      check("pre_abort_ack", {28'b0, req_ack}, 32'h4);
      reset = 1'b1;
      #1;
      check("abort_ack", {28'b0, req_ack}, 32'd0);
      check("abort_outs", {29'b0, cnt_up, cnt_down, busy}, 32'd0);
      check("abort_cnt", {28'b0, cnt}, 32'd0);
      @(posedge clk) #1;
      reset = 1'b0;
      push(0, 1'b0, 1'b1, 1'b0);
      push(2, 1'b0, 1'b1, 1'b0);
      wait_ack(4, n);
      @(posedge clk) #1;
      req_valid = 4'b0100;
      wait_ack(4, n);
      @(posedge clk) #1;
      req_valid = '0;
      check("post_abort_cnt", {28'b0, cnt}, 32'd2);

      repeat (2) @(posedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
